// File: rtl/bcd_serial_subtractor_ctrl_if.sv
// Start/done handshake bundle for the digit-serial BCD subtractor.
// Host side (master): start, a, b out; busy, done, result, neg, err in.
interface bcd_serial_subtractor_ctrl_if #(
    parameter int NDIG = 4
);
    logic                start;
    logic [4*NDIG-1:0]   a;
    logic [4*NDIG-1:0]   b;
    logic                busy;
    logic                done;
    logic [4*NDIG-1:0]   result;
    logic                neg;
    logic                err;

    modport master (
        output start, a, b,
        input  busy, done, result, neg, err
    );

    modport slave (
        input  start, a, b,
        output busy, done, result, neg, err
    );
endinterface

// File: rtl/bcd_serial_subtractor_ctrl.sv
// Digit-serial BCD |A-B| sequencer: one digit per clock, LSD first.
// Ports: clk, rst_n (sync, active-low), bus (slave side of handshake/data).
module bcd_serial_subtractor_ctrl #(
    parameter int NDIG = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    bcd_serial_subtractor_ctrl_if.slave bus
);
    localparam int W  = 4 * NDIG;
    localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, SUB, FIX, DONE} state_e;

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d;
    logic [W-1:0]   b_q, b_d;
    logic [W-1:0]   r_q, r_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           carry_q, carry_d;
    logic           neg_q, neg_d;
    logic           err_q, err_d;

    logic [3:0]     cin;
    logic [3:0]     comp;
    logic [3:0]     addend;
    logic [4:0]     sum;
    logic [3:0]     dig;
    logic           cout;

    function automatic logic has_bad_digit(input logic [W-1:0] v);
        logic bad;
        bad = 1'b0;
        for (int i = 0; i < NDIG; i++) begin
            if (v[4*i +: 4] > 4'd9) bad = 1'b1;
        end
        return bad;
    endfunction

    // Shared 9's-complement cell plus BCD digit adder. The cell input
    // is chosen by state alone: b_i while subtracting, r_i while
    // re-complementing (where the minuend term is zero).
    always_comb begin
        cin    = (state_q == FIX) ? r_q[int'(idx_q)*4 +: 4]
                                  : b_q[int'(idx_q)*4 +: 4];
        comp   = 4'd9 - cin;
        addend = (state_q == SUB) ? a_q[int'(idx_q)*4 +: 4] : 4'd0;
        sum    = {1'b0, addend} + {1'b0, comp} + {4'd0, carry_q};
        cout   = (sum > 5'd9);
        dig    = cout ? 4'(sum - 5'd10) : sum[3:0];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        neg_d   = neg_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    r_d     = '0;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    neg_d   = 1'b0;
                    if (has_bad_digit(bus.a) || has_bad_digit(bus.b)) begin
                        err_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = SUB;
                    end
                end
            end
            SUB: begin
                r_d[int'(idx_q)*4 +: 4] = dig;
                carry_d = cout;
                if (idx_q == LAST) begin
                    idx_d = '0;
                    if (cout) begin
                        neg_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        // No final carry: stored sum is 10^N - |A-B|.
                        neg_d   = 1'b1;
                        carry_d = 1'b1;
                        state_d = FIX;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            FIX: begin
                r_d[int'(idx_q)*4 +: 4] = dig;
                carry_d = cout;
                if (idx_q == LAST) begin
                    idx_d   = '0;
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            neg_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            neg_q   <= neg_d;
            err_q   <= err_d;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = r_q;
    assign bus.neg    = neg_q;
    assign bus.err    = err_q;
endmodule

// File: tb/tb_bcd_serial_subtractor_ctrl.sv
// Self-checking bench for bcd_serial_subtractor_ctrl (NDIG=4).
// Directed cases plus random operands against an arithmetic model.
module tb_bcd_serial_subtractor_ctrl;
    localparam int NDIG = 4;
    localparam int W    = 4 * NDIG;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_pass;

    bcd_serial_subtractor_ctrl_if #(.NDIG(NDIG)) bus ();

    bcd_serial_subtractor_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    function automatic bit bcd_valid(input logic [W-1:0] v);
        for (int i = 0; i < NDIG; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd2int(input logic [W-1:0] v);
        int r;
        r = 0;
        for (int i = NDIG - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int2bcd(input int n);
        logic [W-1:0] r;
        int m;
        r = '0;
        m = n;
        for (int i = 0; i < NDIG; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Apply one operation and check result, flags and latency.
    // Latency = edges from the accept edge t to the edge that samples done=1.
    task automatic run_op(input string tag, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        int  av, bv, lat, exp_lat;
        bit  valid, seen;
        logic [W-1:0] exp_r;
        logic exp_neg;
        valid = bcd_valid(a) && bcd_valid(b);
        av = bcd2int(a);
        bv = bcd2int(b);
        if (!valid) begin
            exp_r = '0; exp_neg = 1'b0; exp_lat = 1;
        end else if (av < bv) begin
            exp_r = int2bcd(bv - av); exp_neg = 1'b1; exp_lat = 2*NDIG + 1;
        end else begin
            exp_r = int2bcd(av - bv); exp_neg = 1'b0; exp_lat = NDIG + 1;
        end
        @(negedge clk);
        bus.a = a;
        bus.b = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = ~a;
        bus.b = ~b;
        lat = 1;
        seen = 1'b0;
        while (!seen && lat < 40) begin
            if (bus.done) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
                lat++;
            end
        end
        if (!seen) begin
            chk({tag, "_timeout"}, 0, 1);
        end else begin
            chk({tag, "_lat"}, lat, exp_lat);
            chk({tag, "_res"}, 32'(bus.result), 32'(exp_r));
            chk({tag, "_neg"}, 32'(bus.neg), 32'(exp_neg));
            chk({tag, "_err"}, 32'(bus.err), 32'(!valid));
            @(posedge clk);
            #1;
            chk({tag, "_pulse"}, 32'(bus.done), 0);
            chk({tag, "_idle"}, 32'(bus.busy), 0);
            chk({tag, "_hold"}, 32'(bus.result), 32'(exp_r));
        end
    endtask

    initial begin
        int dn;
        logic [W-1:0] ra, rb;
        n_chk = 0;
        n_pass = 0;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_res", 32'(bus.result), 0);
        chk("rst_neg", 32'(bus.neg), 0);
        chk("rst_err", 32'(bus.err), 0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("t1", 16'h5432, 16'h1234);
        run_op("t2", 16'h0000, 16'h0001);
        run_op("t3a", 16'h7777, 16'h7777);
        run_op("t3b", 16'h0000, 16'h9999);
        run_op("t4", 16'h12A4, 16'h0000);
        run_op("max", 16'h9999, 16'h0000);

        // Start held high: one done for the first op, second op
        // accepted only on the edge after the done cycle.
        @(negedge clk);
        bus.a = 16'h5432;
        bus.b = 16'h1234;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        dn = 0;
        for (int i = 0; i < NDIG; i++) begin
            if (bus.done) dn++;
            @(posedge clk);
            #1;
        end
        if (bus.done) dn++;
        chk("t5_pulses", dn, 1);
        chk("t5_res", 32'(bus.result), 32'h4198);
        @(posedge clk);
        #1;
        chk("t5_gap", 32'(bus.busy), 0);
        @(posedge clk);
        #1;
        chk("t5_reacc", 32'(bus.busy), 1);
        bus.start = 1'b0;
        dn = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) dn++;
            @(posedge clk);
            #1;
        end
        chk("t5_second", dn, 1);

        // Reset in the middle of the FIX pass.
        @(negedge clk);
        bus.a = 16'h0000;
        bus.b = 16'h0001;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (NDIG + 2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_done", 32'(bus.done), 0);
        chk("t6_res", 32'(bus.result), 0);
        chk("t6_neg", 32'(bus.neg), 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("t6_fresh", 16'h0123, 16'h0456);

        for (int k = 0; k < 60; k++) begin
            for (int i = 0; i < NDIG; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 9) == 0)
                ra[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 9) == 0)
                rb[4*$urandom_range(0, NDIG-1) +: 4] = 4'($urandom_range(10, 15));
            if ($urandom_range(0, 7) == 0) rb = ra;
            run_op($sformatf("rnd%0d", k), ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
